centroid_accum: RTL and testbench
=================================

// Module: centroid_accum
// PURPOSE
//  Downstream of the per-line popcount tree. Accumulates per-line pupil-pixel count (iCOUNT) and x-index sum (iXSUM) over a frame.
//  At frame end, a sequential restoring divider produces the pupil centre of gravity (oCX, oCY).
//  Sits between the binarized-line popcount stage and the gaze-output register block.
// PARAMETERS
//  BIT_WIDTH  5  log2 of pixels per line (line = 1<<BIT_WIDTH px); matches popcount stage
//  Y_WIDTH    6  line-index width; max lines per frame = 1<<Y_WIDTH
//  MIN_AREA   4  minimum accepted area (used only with CENTROID_MIN_AREA_EN)
// PORTS
//  iCLK         in   1              clock, all logic on rising edge
//  iRST         in   1              reset, asynchronous, active-high
//  iFRAME_START in   1              1-cycle pulse: clear accumulators, line index := 0
//  iFRAME_END   in   1              1-cycle pulse: close frame, start division
//  iLINE_VALID  in   1              1-cycle strobe: iCOUNT/iXSUM valid for current line
//  iCOUNT       in   BIT_WIDTH+1    set pixels in line, 0..1<<BIT_WIDTH
//  iXSUM        in   2*BIT_WIDTH    sum of x indices of set pixels
//  oCX          out  BIT_WIDTH      floor(SUMX/AREA)
//  oCY          out  Y_WIDTH        floor(SUMY/AREA)
//  oAREA        out  BIT_WIDTH+1+Y_WIDTH  total frame pixel count
//  oVALID       out  1              1-cycle pulse: oCX/oCY/oAREA/oNO_TARGET updated
//  oNO_TARGET   out  1              1 when AREA==0 (or < MIN_AREA if enabled); oCX/oCY hold previous
//  oOVERFLOW    out  1              1 when >1<<Y_WIDTH lines seen this frame; cleared on iFRAME_START
//  oBUSY        out  1              1 in DIV_X/DIV_Y/DONE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; accumulators and line index 0.
//  States: IDLE -(iFRAME_START)-> ACCUM -(iFRAME_END)-> DIV_X -(BIT_WIDTH cyc)-> DIV_Y -(Y_WIDTH cyc)-> DONE -(1 cyc)-> IDLE.
//  ACCUM, per iLINE_VALID: AREA+=iCOUNT; SUMX+=iXSUM; SUMY+=iCOUNT*y; y++.
//  Widths: AREA BIT_WIDTH+1+Y_WIDTH; SUMX 2*BIT_WIDTH+Y_WIDTH; SUMY BIT_WIDTH+1+2*Y_WIDTH. None can overflow.
//  Line index: if y would exceed (1<<Y_WIDTH)-1, the line is dropped, oOVERFLOW:=1, and y saturates.
//  Divider: restoring, one quotient bit per cycle, MSB first, unsigned, floor; quotient never exceeds its output width.
//  AREA==0: divider skipped in DIV_X/DIV_Y (states still traversed); oNO_TARGET:=1; oCX/oCY unchanged.
//  Latency: oVALID asserts exactly BIT_WIDTH+Y_WIDTH+1 cycles after the iFRAME_END cycle (DONE cycle).
//  Outputs: oCX/oCY/oAREA/oNO_TARGET update in the DONE cycle and hold until the next DONE.
//  iFRAME_START in any state (incl. DIV_*/DONE): abort, clear accumulators/oOVERFLOW, go to ACCUM, no oVALID.
//  iFRAME_START + iLINE_VALID same cycle: clear, then that line accumulates as y=0.
//  iLINE_VALID + iFRAME_END same cycle: line included, then division.
//  iLINE_VALID outside ACCUM and iFRAME_END outside ACCUM: ignored.
//  Async reset mid-division: immediate return to reset state, no oVALID.
// CONFIGURATION
//  `define CENTROID_MIN_AREA_EN:
//    AREA < MIN_AREA is treated as no target: oNO_TARGET=1, divider skipped, oCX/oCY hold.
//  Undefined: only AREA==0 gives oNO_TARGET; MIN_AREA is unused.
// TESTING (BIT_WIDTH=5, Y_WIDTH=6)
//  1. FRAME_START; lines y=0..2 COUNT=0; y=3 COUNT=4 XSUM=42; y=4 COUNT=4 XSUM=42; FRAME_END
//     -> 12 cyc later oVALID, oAREA=8, oCX=10, oCY=3, oNO_TARGET=0.
//  2. FRAME_START; 5 lines COUNT=0; FRAME_END -> oVALID, oNO_TARGET=1, oCX/oCY = test-1 values.
//  3. FRAME_START; 70 lines COUNT=1 XSUM=7 -> oOVERFLOW=1 after 65th line; FRAME_END
//     -> oAREA=64, oCX=7, oCY=31.
//  4. FRAME_END, then FRAME_START 3 cycles later (mid DIV_X) -> no oVALID; oBUSY=0 next cycle; new frame accumulates cleanly.
//  5. Single line COUNT=32 XSUM=496 with LINE_VALID+FRAME_END same cycle -> oAREA=32, oCX=15, oCY=0.
//  6. CENTROID_MIN_AREA_EN, MIN_AREA=4: frame AREA=3 -> oNO_TARGET=1; iRST mid-DIV_Y -> all outputs 0, no oVALID.

Source files
------------

// File: rtl/centroid_accum.sv
// -----------------------------------------------------------------------------
// centroid_accum
//
// Purpose:
//   Accumulates per-line pupil pixel counts and x-index sums over a frame. At
//   frame end, a sequential restoring divider produces the pupil centre of
//   gravity. The x quotient is computed first, then the y quotient. The
//   divider yields one quotient bit per cycle, MSB first.
//
// Ports:
//   iCLK          clock, rising edge
//   iRST          asynchronous active-high reset
//   iFRAME_START  pulse: clear accumulators, line index := 0, enter ACCUM
//   iFRAME_END    pulse: close frame, start division (only honoured in ACCUM)
//   iLINE_VALID   strobe: iCOUNT/iXSUM valid for the current line
//   iCOUNT        set pixels in the line, 0..(1<<BIT_WIDTH)
//   iXSUM         sum of x indices of the set pixels
//   oCX           floor(SUMX/AREA)
//   oCY           floor(SUMY/AREA)
//   oAREA         total pixel count of the last completed frame
//   oVALID        one-cycle pulse in the DONE cycle
//   oNO_TARGET    area too small, so oCX/oCY keep their previous values
//   oOVERFLOW     more lines than the line index can address were seen
//   oBUSY         high in DIV_X / DIV_Y / DONE
//
// Configuration:
//   `define CENTROID_MIN_AREA_EN makes any AREA < MIN_AREA count as no target.
//   Without it, only AREA == 0 counts as no target.
// -----------------------------------------------------------------------------
module centroid_accum #(
  parameter int BIT_WIDTH = 5,
  parameter int Y_WIDTH   = 6,
  parameter int MIN_AREA  = 4
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iFRAME_START,
  input  logic                         iFRAME_END,
  input  logic                         iLINE_VALID,
  input  logic [BIT_WIDTH:0]           iCOUNT,
  input  logic [2*BIT_WIDTH-1:0]       iXSUM,
  output logic [BIT_WIDTH-1:0]         oCX,
  output logic [Y_WIDTH-1:0]           oCY,
  output logic [BIT_WIDTH+Y_WIDTH:0]   oAREA,
  output logic                         oVALID,
  output logic                         oNO_TARGET,
  output logic                         oOVERFLOW,
  output logic                         oBUSY
);

  localparam int AREA_W = BIT_WIDTH + 1 + Y_WIDTH;
  localparam int SX_W   = 2*BIT_WIDTH + Y_WIDTH;
  localparam int SY_W   = BIT_WIDTH + 1 + 2*Y_WIDTH;
  localparam int Q_W    = (BIT_WIDTH > Y_WIDTH) ? BIT_WIDTH : Y_WIDTH;
  localparam int CNT_W  = $clog2(Q_W) + 1;

`ifdef CENTROID_MIN_AREA_EN
  localparam bit USE_MIN_AREA = 1'b1;
`else
  localparam bit USE_MIN_AREA = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, DONE} state_t;

  state_t              state_reg;
  logic [AREA_W-1:0]   area_reg;
  logic [SX_W-1:0]     sumx_reg;
  logic [SY_W-1:0]     sumy_reg;
  logic [Y_WIDTH-1:0]  y_reg;
  // Set once the last addressable line has been taken. From then on y_reg
  // stays saturated and further lines are dropped.
  logic                full_reg;
  logic                skip_reg;
  logic [AREA_W-1:0]   rem_reg;
  logic [Q_W-1:0]      low_reg;   // remaining dividend bits, MSB-aligned
  logic [Q_W-1:0]      q_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [BIT_WIDTH-1:0] cx_res_reg;

  // Next accumulator values. A frame start clears the accumulators first, so a
  // line arriving in the same cycle accumulates as y = 0.
  logic [AREA_W-1:0]   area_base, area_next;
  logic [SX_W-1:0]     sumx_base, sumx_next;
  logic [SY_W-1:0]     sumy_base, sumy_next;
  logic [Y_WIDTH-1:0]  y_base, y_next;
  logic                full_base, full_next;
  logic                ovf_base, ovf_next;
  logic                line_take;
  logic                skip_next;

  assign line_take = iLINE_VALID && (iFRAME_START || (state_reg == ACCUM));

  always_comb begin
    if (iFRAME_START) begin
      area_base = '0;
      sumx_base = '0;
      sumy_base = '0;
      y_base    = '0;
      full_base = 1'b0;
      ovf_base  = 1'b0;
    end else begin
      area_base = area_reg;
      sumx_base = sumx_reg;
      sumy_base = sumy_reg;
      y_base    = y_reg;
      full_base = full_reg;
      ovf_base  = oOVERFLOW;
    end
    area_next = area_base;
    sumx_next = sumx_base;
    sumy_next = sumy_base;
    y_next    = y_base;
    full_next = full_base;
    ovf_next  = ovf_base;
    if (line_take) begin
      if (full_base) begin
        ovf_next = 1'b1;
      end else begin
        area_next = area_base + AREA_W'(iCOUNT);
        sumx_next = sumx_base + SX_W'(iXSUM);
        sumy_next = sumy_base + SY_W'(iCOUNT) * SY_W'(y_base);
        if (y_base == {Y_WIDTH{1'b1}}) begin
          full_next = 1'b1;
        end else begin
          y_next = y_base + Y_WIDTH'(1);
        end
      end
    end
  end

  // The divisor is always the frame area, which is frozen once division starts.
  assign skip_next = (area_next == '0) ||
                     (USE_MIN_AREA && (area_next < AREA_W'(MIN_AREA)));

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if it fits. The remainder stays below the area, so the trial value
  // needs only one extra bit.
  logic [AREA_W:0]   trial;
  logic              fits;
  logic [AREA_W-1:0] rem_step;
  logic [Q_W-1:0]    q_step;

  always_comb begin
    trial    = {rem_reg, low_reg[Q_W-1]};
    fits     = (trial >= {1'b0, area_reg});
    rem_step = fits ? AREA_W'(trial - {1'b0, area_reg}) : trial[AREA_W-1:0];
    q_step   = (q_reg << 1) | Q_W'(fits);
  end

  // Divider preload. The quotient is known to fit in Q bits, so dividend >> Q
  // is already smaller than the divisor and can seed the remainder directly.
  logic [AREA_W-1:0] x_rem_load, y_rem_load;
  logic [Q_W-1:0]    x_low_load, y_low_load;

  assign x_rem_load = AREA_W'(sumx_next >> BIT_WIDTH);
  assign x_low_load = Q_W'(sumx_next[BIT_WIDTH-1:0]) << (Q_W - BIT_WIDTH);
  assign y_rem_load = AREA_W'(sumy_reg >> Y_WIDTH);
  assign y_low_load = Q_W'(sumy_reg[Y_WIDTH-1:0]) << (Q_W - Y_WIDTH);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg  <= IDLE;
      area_reg   <= '0;
      sumx_reg   <= '0;
      sumy_reg   <= '0;
      y_reg      <= '0;
      full_reg   <= 1'b0;
      skip_reg   <= 1'b0;
      rem_reg    <= '0;
      low_reg    <= '0;
      q_reg      <= '0;
      cnt_reg    <= '0;
      cx_res_reg <= '0;
      oCX        <= '0;
      oCY        <= '0;
      oAREA      <= '0;
      oVALID     <= 1'b0;
      oNO_TARGET <= 1'b0;
      oOVERFLOW  <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      area_reg  <= area_next;
      sumx_reg  <= sumx_next;
      sumy_reg  <= sumy_next;
      y_reg     <= y_next;
      full_reg  <= full_next;
      oOVERFLOW <= ovf_next;
      oVALID    <= 1'b0;

      if (iFRAME_START) begin
        // Abort whatever is in flight; no result is published.
        state_reg <= ACCUM;
        oBUSY     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;
          ACCUM: begin
            if (iFRAME_END) begin
              state_reg <= DIV_X;
              oBUSY     <= 1'b1;
              skip_reg  <= skip_next;
              rem_reg   <= x_rem_load;
              low_reg   <= x_low_load;
              q_reg     <= '0;
              cnt_reg   <= '0;
            end
          end
          DIV_X: begin
            if (!skip_reg) begin
              rem_reg <= rem_step;
              low_reg <= low_reg << 1;
              q_reg   <= q_step;
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(BIT_WIDTH - 1)) begin
              cx_res_reg <= q_step[BIT_WIDTH-1:0];
              rem_reg    <= y_rem_load;
              low_reg    <= y_low_load;
              q_reg      <= '0;
              cnt_reg    <= '0;
              state_reg  <= DIV_Y;
            end
          end
          DIV_Y: begin
            if (!skip_reg) begin
              rem_reg <= rem_step;
              low_reg <= low_reg << 1;
              q_reg   <= q_step;
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(Y_WIDTH - 1)) begin
              state_reg  <= DONE;
              oVALID     <= 1'b1;
              oAREA      <= area_reg;
              oNO_TARGET <= skip_reg;
              if (!skip_reg) begin
                oCX <= cx_res_reg;
                oCY <= q_step[Y_WIDTH-1:0];
              end
            end
          end
          DONE: begin
            state_reg <= IDLE;
            oBUSY     <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            oBUSY     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_centroid_accum.sv
// -----------------------------------------------------------------------------
// tb_centroid_accum
//
// Drives directed frames and then random frames into centroid_accum. A
// frame-level model (line list -> sums -> integer division) predicts every
// output on every cycle.
// -----------------------------------------------------------------------------
module tb_centroid_accum;
  localparam int BW   = 5;
  localparam int YW   = 6;
  localparam int MINA = 4;
  localparam int LAT  = BW + YW + 1;
  localparam int NMAX = 1 << YW;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b0;
  logic              iFRAME_START = 1'b0;
  logic              iFRAME_END = 1'b0;
  logic              iLINE_VALID = 1'b0;
  logic [BW:0]       iCOUNT = '0;
  logic [2*BW-1:0]   iXSUM = '0;
  logic [BW-1:0]     oCX;
  logic [YW-1:0]     oCY;
  logic [BW+YW:0]    oAREA;
  logic              oVALID, oNO_TARGET, oOVERFLOW, oBUSY;

  centroid_accum #(.BIT_WIDTH(BW), .Y_WIDTH(YW), .MIN_AREA(MINA)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFRAME_START(iFRAME_START),
    .iFRAME_END(iFRAME_END), .iLINE_VALID(iLINE_VALID), .iCOUNT(iCOUNT),
    .iXSUM(iXSUM), .oCX(oCX), .oCY(oCY), .oAREA(oAREA), .oVALID(oVALID),
    .oNO_TARGET(oNO_TARGET), .oOVERFLOW(oOVERFLOW), .oBUSY(oBUSY)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int     cyc = 0;
  int     fe_cyc = 0;
  bit     in_accum = 0;
  bit     active = 0;
  longint m_area = 0, m_sx = 0, m_sy = 0;
  int     m_lines = 0;
  bit     m_ovf = 0;
  bit     e_valid = 0, e_busy = 0, e_nt = 0;
  longint e_cx = 0, e_cy = 0, e_area = 0;

  function automatic bit no_target(input longint a);
`ifdef CENTROID_MIN_AREA_EN
    return a < MINA;
`else
    return a == 0;
`endif
  endfunction

  task automatic model_add_line();
    if (m_lines >= NMAX) begin
      m_ovf = 1;
    end else begin
      m_area += iCOUNT;
      m_sx   += iXSUM;
      m_sy   += longint'(iCOUNT) * m_lines;
      m_lines++;
    end
  endtask

  initial begin
    forever begin
      @(posedge iCLK or posedge iRST);
      if (iRST) begin
        cyc = 0; in_accum = 0; active = 0;
        m_area = 0; m_sx = 0; m_sy = 0; m_lines = 0; m_ovf = 0;
        e_valid = 0; e_busy = 0; e_nt = 0; e_cx = 0; e_cy = 0; e_area = 0;
      end else begin
        cyc++;
        if (iFRAME_START) begin
          in_accum = 1; active = 0;
          m_area = 0; m_sx = 0; m_sy = 0; m_lines = 0; m_ovf = 0;
          if (iLINE_VALID) model_add_line();
        end else if (in_accum) begin
          if (iLINE_VALID) model_add_line();
          if (iFRAME_END) begin
            in_accum = 0; active = 1; fe_cyc = cyc;
          end
        end
        // Result appears LAT cycles after the frame-end cycle (cyc-1).
        e_valid = active && (cyc == fe_cyc + LAT - 1);
        e_busy  = active && (cyc >= fe_cyc) && (cyc <= fe_cyc + LAT - 1);
        if (e_valid) begin
          e_area = m_area;
          e_nt   = no_target(m_area);
          if (!e_nt) begin
            e_cx = m_sx / m_area;
            e_cy = m_sy / m_area;
          end
        end
        if (active && cyc >= fe_cyc + LAT - 1) active = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge iCLK);
      chk("valid", oVALID, e_valid);
      chk("busy", oBUSY, e_busy);
      chk("overflow", oOVERFLOW, m_ovf);
      chk("area", oAREA, e_area);
      chk("no_target", oNO_TARGET, e_nt);
      chk("cx", oCX, e_cx);
      chk("cy", oCY, e_cy);
      if (oVALID)
        $display("frame done: area=%0d cx=%0d cy=%0d no_target=%0d overflow=%0d",
                 oAREA, oCX, oCY, oNO_TARGET, oOVERFLOW);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit fs, input bit lv, input bit fe, input int c, input int x);
    iFRAME_START = fs; iLINE_VALID = lv; iFRAME_END = fe;
    iCOUNT = (BW+1)'(c); iXSUM = (2*BW)'(x);
    @(posedge iCLK); #1;
    iFRAME_START = 0; iLINE_VALID = 0; iFRAME_END = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    bit seen = 0;
    int lat = 0;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(negedge iCLK);
      if (!seen && oVALID) begin
        seen = 1;
        lat = k;
      end
      if (seen) break;
    end
    chk({name, " valid seen"}, seen, 1);
    if (seen) chk({name, " latency"}, lat, exp_lat);
  endtask

  // A plausible x-index sum for c set pixels in a 32-pixel line.
  function automatic int gen_x(input int c);
    int lo;
    lo = c * (c - 1) / 2;
    return lo + int'($urandom_range(0, c * (32 - c)));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int nv;
    int nl;
    int mode;
    int c;
    #1 iRST = 1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset valid", oVALID, 0);
    chk("reset area", oAREA, 0);
    chk("reset busy", oBUSY, 0);
    chk("reset cx", oCX, 0);
    #1 iRST = 0;
    @(posedge iCLK); #1;

    // Test 1: two lines of 4 pixels at y=3 and y=4.
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 4, 42);
    drive(0, 1, 0, 4, 42);
    drive(0, 0, 1, 0, 0);
    wait_valid("t1", LAT);
    chk("t1 area", oAREA, 8);
    chk("t1 cx", oCX, 10);
    chk("t1 cy", oCY, 3);
    chk("t1 no_target", oNO_TARGET, 0);

    // Test 2: empty frame keeps the previous centre.
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    wait_valid("t2", LAT);
    chk("t2 no_target", oNO_TARGET, 1);
    chk("t2 cx", oCX, 10);
    chk("t2 cy", oCY, 3);
    chk("t2 area", oAREA, 0);

    // Test 3: too many lines.
    drive(1, 0, 0, 0, 0);
    for (int k = 1; k <= 70; k++) begin
      drive(0, 1, 0, 1, 7);
      if (k == 64) chk("t3 ovf after 64", oOVERFLOW, 0);
      if (k == 65) chk("t3 ovf after 65", oOVERFLOW, 1);
    end
    drive(0, 0, 1, 0, 0);
    wait_valid("t3", LAT);
    chk("t3 area", oAREA, 64);
    chk("t3 cx", oCX, 7);
    chk("t3 cy", oCY, 31);

    // Test 4: abort mid DIV_X, then a clean frame.
    drive(1, 0, 0, 0, 0);
    chk("t4 ovf cleared", oOVERFLOW, 0);
    drive(0, 1, 0, 2, 10);
    drive(0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0, 0);
    chk("t4 busy after abort", oBUSY, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 3, 30);
    drive(0, 1, 0, 1, 5);
    drive(0, 0, 1, 0, 0);
    wait_valid("t4", LAT);
    chk("t4 area", oAREA, 4);
    chk("t4 cx", oCX, 8);
    chk("t4 cy", oCY, 1);

    // Test 5: line and frame end in the same cycle.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, 32, 496);
    wait_valid("t5", LAT);
    chk("t5 area", oAREA, 32);
    chk("t5 cx", oCX, 15);
    chk("t5 cy", oCY, 0);

    // Test 6: small area, then reset in the middle of DIV_Y.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 3, 9);
    drive(0, 0, 1, 0, 0);
    wait_valid("t6", LAT);
    chk("t6 area", oAREA, 3);
`ifdef CENTROID_MIN_AREA_EN
    chk("t6 no_target", oNO_TARGET, 1);
    chk("t6 cx", oCX, 15);
`else
    chk("t6 no_target", oNO_TARGET, 0);
    chk("t6 cx", oCX, 3);
`endif
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 5, 50);
    drive(0, 0, 1, 0, 0);
    idle(7);
    #2 iRST = 1;
    #1;
    chk("t6 rst valid", oVALID, 0);
    chk("t6 rst busy", oBUSY, 0);
    chk("t6 rst area", oAREA, 0);
    chk("t6 rst cx", oCX, 0);
    chk("t6 rst cy", oCY, 0);
    chk("t6 rst no_target", oNO_TARGET, 0);
    @(posedge iCLK); #1;
    iRST = 0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge iCLK);
      if (oVALID) nv++;
    end
    chk("t6 no valid after reset", nv, 0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      mode = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) drive(1, 1, 0, 2, 20);
      else drive(1, 0, 0, 0, 0);
      nl = (mode == 3) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 20));
      for (int k = 0; k < nl; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (mode == 1) c = 0;
        else if (mode == 2) c = int'($urandom_range(0, 1));
        else c = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 32));
        drive(0, 1, 0, c, gen_x(c));
      end
      if ($urandom_range(0, 3) == 0) begin
        c = int'($urandom_range(0, 32));
        drive(0, 1, 1, c, gen_x(c));
      end else begin
        drive(0, 0, 1, 0, 0);
      end
      if (mode == 0) begin
        idle(int'($urandom_range(0, LAT)));
      end else begin
        drive(0, 1, 1, 5, 20);   // ignored outside ACCUM
        idle(LAT + 2);
      end
    end
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
